// File: rtl/sample_seq_pkg.sv
// Shared types for the sample sequencer: FSM state encoding and the queued sample entry.
// Entry field widths are fixed here and track the sequencer's default parameters.
package sample_seq_pkg;

  localparam int unsigned SEQ_NUM_CH = 2;
  localparam int unsigned SEQ_DATA_W = 32;
  localparam int unsigned SEQ_CNT_W  = 16;
  localparam int unsigned SEQ_CH_W   = (SEQ_NUM_CH > 1) ? $clog2(SEQ_NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SCAN  = 2'd2,
    ST_FLUSH = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [SEQ_CH_W-1:0]   ch;
    logic [SEQ_DATA_W-1:0] data;
    logic [SEQ_CNT_W-1:0]  seq;
  } sample_entry_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO of sample entries with registered status; head reads the storage directly.
// A push into a full FIFO is dropped even when a pop happens in the same cycle.
module sample_fifo
  import sample_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  sample_entry_t push_entry,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output sample_entry_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  sample_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic [OCC_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + OCC_W'(1);
      2'b01:   count_nxt = count - OCC_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == OCC_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sample_sequencer.sv
// Programmable multi-channel sampling engine: snapshots enabled channels every period cycles
// for a programmed number of ticks and serialises them through a FIFO to a valid/ready consumer.
module sample_sequencer
  import sample_seq_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         period,
  input  logic [CNT_W-1:0]         num_samples,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic [CNT_W-1:0]         out_seq,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     missed
);

  seq_state_e               state;
  seq_state_e               state_nxt;
  logic [CNT_W-1:0]         period_q;
  logic [CNT_W-1:0]         num_q;
  logic [NUM_CH-1:0]        en_q;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         seq;
  logic [CH_W-1:0]          idx;
  logic [NUM_CH*DATA_W-1:0] hold;

  logic          accept;
  logic          snap;
  logic          push;
  logic          done_nxt;
  logic          tick;
  logic          last_ch;
  logic          last_tick;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  sample_entry_t push_entry;
  sample_entry_t head;

  assign tick      = (cnt == '0);
  assign last_ch   = (idx == CH_W'(NUM_CH - 1));
  assign last_tick = (seq == num_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the one-cycle control strobes for the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    snap      = 1'b0;
    push      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (period != '0) && (num_samples != '0)) begin
          accept    = 1'b1;
          state_nxt = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (tick) begin
          snap      = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        push = en_q[idx];
        if (last_ch) begin
          state_nxt = last_tick ? ST_FLUSH : ST_COUNT;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Configuration latch, tick counter (free-running through SCAN), snapshot and scan bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      num_q    <= '0;
      en_q     <= '0;
      cnt      <= '0;
      seq      <= '0;
      idx      <= '0;
      hold     <= '0;
      overflow <= 1'b0;
      missed   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= done_nxt;
      busy <= (state_nxt != ST_IDLE);
      if (accept) begin
        period_q <= period;
        num_q    <= num_samples;
        en_q     <= ch_en;
        cnt      <= period - CNT_W'(1);
        seq      <= '0;
        overflow <= 1'b0;
        missed   <= 1'b0;
      end
      if ((state == ST_COUNT) || (state == ST_SCAN)) begin
        cnt <= tick ? (period_q - CNT_W'(1)) : (cnt - CNT_W'(1));
      end
      if (snap) begin
        hold <= ch_data;
        idx  <= '0;
      end
      if (state == ST_SCAN) begin
        if (tick) begin
          missed <= 1'b1;
        end
        if (push && fifo_full) begin
          overflow <= 1'b1;
        end
        if (!last_ch) begin
          idx <= idx + CH_W'(1);
        end else if (!last_tick) begin
          seq <= seq + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.ch   = SEQ_CH_W'(idx);
    push_entry.data = SEQ_DATA_W'(hold[32'(idx) * DATA_W +: DATA_W]);
    push_entry.seq  = SEQ_CNT_W'(seq);
  end

  assign pop = !fifo_empty && out_ready;

  sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign out_valid = !fifo_empty;
  assign out_ch    = CH_W'(head.ch);
  assign out_data  = DATA_W'(head.data);
  assign out_seq   = CNT_W'(head.seq);

endmodule

// File: tb/tb_sample_sequencer.sv
// Randomised bench for sample_sequencer against a tick-schedule reference model with a depth-limited queue.
module tb_sample_sequencer;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DEPTH  = 4;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [CNT_W-1:0]         period;
  logic [CNT_W-1:0]         num_samples;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [0:0]               out_ch;
  logic [DATA_W-1:0]        out_data;
  logic [CNT_W-1:0]         out_seq;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  logic                     missed;

  sample_sequencer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .period(period), .num_samples(num_samples),
    .ch_en(ch_en), .ch_data(ch_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .out_seq(out_seq), .busy(busy), .done(done),
    .overflow(overflow), .missed(missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          seq;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: ticks land at start+k*period; a tick arriving while a scan is
  // in progress is lost; channel i of a scan is offered one cycle after snapshot+i.
  bit          m_busy, m_done, m_ovf, m_missed, m_flush, m_scan;
  int          m_t, m_next_tick, m_s, m_per, m_n, m_processed;
  logic [1:0]  m_en;
  logic [63:0] m_snap;

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_done = 0; m_ovf = 0; m_missed = 0; m_flush = 0; m_scan = 0;
    m_t = 0; m_next_tick = 0; m_s = 0; m_per = 0; m_n = 0; m_processed = 0;
    m_en = '0; m_snap = '0;
  endtask

  task automatic model_edge(input bit st, input int per, input int n, input logic [1:0] en,
                            input bit rdy, input logic [63:0] d);
    int   pre;
    int   i;
    bit   tick;
    bit   have_push;
    exp_t e;
    pre = q.size();
    have_push = 0;
    e = '{ch: 0, data: '0, seq: 0};
    m_done = 0;
    m_t++;
    if (!m_busy) begin
      if (st && per != 0 && n != 0) begin
        m_busy = 1; m_per = per; m_n = n; m_en = en;
        m_next_tick = m_t + per;
        m_scan = 0; m_flush = 0; m_processed = 0; m_ovf = 0; m_missed = 0;
      end
    end else if (m_flush) begin
      if (pre == 0) begin
        m_done = 1;
        m_busy = 0;
      end
    end else begin
      tick = (m_t == m_next_tick);
      if (tick) m_next_tick += m_per;
      if (m_scan) begin
        i = m_t - m_s - 1;
        if (m_en[i]) begin
          have_push = 1;
          e.ch = i;
          e.data = m_snap[i*32 +: 32];
          e.seq = m_processed;
        end
        if (tick) m_missed = 1;
        if (i == int'(NUM_CH) - 1) begin
          m_scan = 0;
          m_processed++;
          if (m_processed == m_n) m_flush = 1;
        end
      end else if (tick) begin
        m_scan = 1;
        m_s = m_t;
        m_snap = d;
      end
    end
    if (rdy && pre > 0) void'(q.pop_front());
    if (have_push) begin
      if (pre < int'(DEPTH)) q.push_back(e);
      else m_ovf = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("missed", 64'(missed), 64'(m_missed));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_ch", 64'(out_ch), 64'(q[0].ch));
      chk("out_data", 64'(out_data), 64'(q[0].data));
      chk("out_seq", 64'(out_seq), 64'(q[0].seq));
    end
  endtask

  // One clock: check what the last edge produced, then drive inputs for the next edge.
  task automatic cycle(input bit st, input int per, input int n, input logic [1:0] en, input bit rdy);
    logic [63:0] d;
    @(negedge clk);
    check_outputs();
    d = {$urandom, $urandom};
    start = st;
    period = CNT_W'(per);
    num_samples = CNT_W'(n);
    ch_en = en;
    out_ready = rdy;
    ch_data = d;
    model_edge(st, per, n, en, rdy, d);
  endtask

  // mode 0: always ready; 1: stalled until the run is flushing; 2: random ready.
  task automatic run(input int per, input int n, input logic [1:0] en, input int mode, input bit poke);
    int cyc;
    int limit;
    bit rdy;
    bit st;
    cycle(1, per, n, en, 1'b1);
    cyc = 0;
    limit = per * (n + 1) + int'(NUM_CH) * n + 20;
    while (m_busy && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = m_flush;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (cyc > limit) rdy = 1'b1;
      st = poke && ($urandom_range(0, 5) == 0);
      cycle(st, int'($urandom_range(1, 9)), int'($urandom_range(1, 5)), 2'($urandom), rdy);
      cyc++;
    end
    cycle(0, 0, 0, 2'b00, 1'b1);
    chk("run_end_busy", 64'(busy), 64'(0));
    cycle(0, 0, 0, 2'b00, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; period = '0; num_samples = '0; ch_en = '0;
    ch_data = '0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_missed", 64'(missed), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_ch", 64'(out_ch), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_seq", 64'(out_seq), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 2'b00, 1'b1);

    run(5, 3, 2'b11, 0, 1'b1);
    chk("tp1_overflow", 64'(overflow), 64'(0));
    chk("tp1_missed", 64'(missed), 64'(0));

    run(5, 3, 2'b11, 1, 1'b0);
    chk("tp2_overflow", 64'(overflow), 64'(1));

    run(5, 2, 2'b10, 0, 1'b0);

    run(1, 4, 2'b11, 0, 1'b0);
    chk("tp4_missed", 64'(missed), 64'(1));

    cycle(1, 5, 0, 2'b11, 1'b1);
    cycle(0, 0, 0, 2'b00, 1'b1);
    chk("zero_samples_ignored", 64'(busy), 64'(0));
    cycle(1, 0, 3, 2'b11, 1'b1);
    cycle(0, 0, 0, 2'b00, 1'b1);
    chk("zero_period_ignored", 64'(busy), 64'(0));

    // Reset while scanning the second tick with two entries held.
    cycle(1, 5, 3, 2'b11, 1'b0);
    guard = 0;
    while (!(m_scan && q.size() == 2) && guard < 100) begin
      cycle(0, 0, 0, 2'b00, 1'b0);
      guard++;
    end
    chk("reset_setup_reached", 64'(guard < 100), 64'(1));
    @(posedge clk);
    #2;
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_data", 64'(out_data), 64'(0));
    chk("midrst_seq", 64'(out_seq), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    model_reset();
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 2'b00, 1'b1);
    run(5, 2, 2'b11, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      run(int'($urandom_range(1, 7)), int'($urandom_range(1, 4)), 2'($urandom),
          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
